// File: rtl/bram_session_pkg.sv
// Shared types and constants for the debug-BRAM session controller.
package bram_session_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [3:0]  WE_ALL    = 4'b1111;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_D,
        ST_LOAD_I,
        ST_CORE_RST,
        ST_RUN,
        ST_DUMP_D,
        ST_DUMP_I,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bram_word_seq.sv
// Word index counter, byte-address generator and one-cycle read-capture
// register shared by whichever RAM port the controller currently owns.
module bram_word_seq
    import bram_session_pkg::*;
#(
    parameter int WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              launch,
    input  logic [WORD_W-1:0] rd,
    output logic [WORD_W-1:0] addr,
    output logic [WORD_W-1:0] data,
    output logic              at_last
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [IDX_W-1:0]  idx;
    logic              fresh;
    logic [WORD_W-1:0] hold;

    // Word index: cleared at region boundaries, stepped per accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // fresh marks the cycle right after an address cycle, when rd is valid;
    // the value is latched so it stays put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh <= 1'b0;
            hold  <= '0;
        end else begin
            fresh <= launch;
            if (fresh) begin
                hold <= rd;
            end
        end
    end

    assign addr    = WORD_W'(idx) * ADDR_STEP;
    assign data    = fresh ? rd : hold;
    assign at_last = (idx == IDX_W'(WORDS - 1));

endmodule

// File: rtl/bram_session_ctrl.sv
// Session controller for the RV32Core debug BRAM ports: loads Data then
// Instruction RAM from a stream, pulses core reset, runs the core for a
// fixed budget, then dumps both RAMs word by word.
module bram_session_ctrl
    import bram_session_pkg::*;
#(
    parameter int WORDS      = 4096,
    parameter int RUN_CYCLES = 200000,
    parameter int RST_CYCLES = 5
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        dp_valid,
    input  logic        dp_ready,
    output logic [31:0] dp_data,
    output logic        dp_last,
    output logic        core_rst,
    output logic [31:0] dram_a2,
    output logic [31:0] iram_a2,
    output logic [31:0] dram_wd2,
    output logic [31:0] iram_wd2,
    output logic [3:0]  dram_we2,
    output logic [3:0]  iram_we2,
    input  logic [31:0] dram_rd2,
    input  logic [31:0] iram_rd2,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);

    state_t      state;
    logic [31:0] cnt;

    logic        idle_like;
    logic        dump_st;
    logic        beat;
    logic        load_end;
    logic        hs;
    logic        run_end;
    logic        seq_clr;
    logic        seq_inc;
    logic        seq_launch;
    logic        seq_last;
    logic [31:0] seq_addr;
    logic [31:0] seq_data;
    logic [31:0] rd_sel;
    logic        dram_own;
    logic        iram_own;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign dump_st   = (state == ST_DUMP_D) || (state == ST_DUMP_I);
    // ld_ready is only ever high in the two load states
    assign beat      = ld_valid && ld_ready;
    assign load_end  = beat && (ld_last || seq_last);
    assign hs        = dump_st && dp_valid && dp_ready;
    assign run_end   = (state == ST_RUN) && (cnt == RUN_LAST);

    assign seq_clr    = (idle_like && start) || load_end || run_end || (hs && seq_last);
    assign seq_inc    = (beat && !load_end) || (hs && !seq_last);
    // In a dump state, dp_valid low means this is the address cycle.
    assign seq_launch = dump_st && !dp_valid;
    assign rd_sel     = (state == ST_DUMP_I) ? iram_rd2 : dram_rd2;

    bram_word_seq #(
        .WORDS (WORDS)
    ) u_seq (
        .clk     (CPU_CLK),
        .rst_n   (CPU_RST_N),
        .clr     (seq_clr),
        .inc     (seq_inc),
        .launch  (seq_launch),
        .rd      (rd_sel),
        .addr    (seq_addr),
        .data    (seq_data),
        .at_last (seq_last)
    );

    // Port-2 mux: only the RAM owned by the current state sees the address;
    // writes happen combinationally in the beat's transfer cycle.
    assign dram_own = (state == ST_LOAD_D) || (state == ST_DUMP_D);
    assign iram_own = (state == ST_LOAD_I) || (state == ST_DUMP_I);
    assign dram_a2  = dram_own ? seq_addr : '0;
    assign iram_a2  = iram_own ? seq_addr : '0;
    assign dram_we2 = ((state == ST_LOAD_D) && beat) ? WE_ALL : '0;
    assign iram_we2 = ((state == ST_LOAD_I) && beat) ? WE_ALL : '0;
    assign dram_wd2 = ((state == ST_LOAD_D) && beat) ? ld_data : '0;
    assign iram_wd2 = ((state == ST_LOAD_I) && beat) ? ld_data : '0;
    assign dp_data  = seq_data;

    // Session FSM with registered handshake and status outputs.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ld_ready <= 1'b0;
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD_D;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ST_LOAD_D: begin
                    if (load_end) begin
                        state <= ST_LOAD_I;
                    end
                end
                ST_LOAD_I: begin
                    if (load_end) begin
                        state    <= ST_CORE_RST;
                        ld_ready <= 1'b0;
                        core_rst <= 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_CORE_RST: begin
                    if (cnt == RST_LAST) begin
                        state    <= ST_RUN;
                        core_rst <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (run_end) begin
                        state    <= ST_DUMP_D;
                        core_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DUMP_D, ST_DUMP_I: begin
                    if (!dp_valid) begin
                        dp_valid <= 1'b1;
                        dp_last  <= (state == ST_DUMP_I) && seq_last;
                    end else if (dp_ready) begin
                        dp_valid <= 1'b0;
                        dp_last  <= 1'b0;
                        if (seq_last) begin
                            if (state == ST_DUMP_D) begin
                                state <= ST_DUMP_I;
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_session_ctrl.sv
// Randomized bench for bram_session_ctrl with a session-level reference model.
module tb_bram_session_ctrl;

    localparam int WORDS  = 8;
    localparam int RUNC   = 20;
    localparam int RSTC   = 5;
    localparam int IW     = $clog2(WORDS);

    localparam int M_IDLE = 0, M_LD_D = 1, M_LD_I = 2, M_RST = 3,
                   M_RUN = 4, M_DP_D = 5, M_DP_I = 6, M_DONE = 7;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic        start, ld_valid, ld_ready, ld_last;
    logic [31:0] ld_data;
    logic        dp_valid, dp_ready, dp_last;
    logic [31:0] dp_data;
    logic        core_rst, busy, done;
    logic [31:0] dram_a2, iram_a2, dram_wd2, iram_wd2, dram_rd2, iram_rd2;
    logic [3:0]  dram_we2, iram_we2;

    bram_session_ctrl #(.WORDS(WORDS), .RUN_CYCLES(RUNC), .RST_CYCLES(RSTC)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data), .dp_last(dp_last),
        .core_rst(core_rst),
        .dram_a2(dram_a2), .iram_a2(iram_a2), .dram_wd2(dram_wd2), .iram_wd2(iram_wd2),
        .dram_we2(dram_we2), .iram_we2(iram_we2), .dram_rd2(dram_rd2), .iram_rd2(iram_rd2),
        .busy(busy), .done(done)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int errors = 0;
    int checks = 0;

    // physical RAMs and the reference image the model maintains
    logic [31:0] dmem [WORDS];
    logic [31:0] imem [WORDS];
    logic [31:0] ref_d [WORDS];
    logic [31:0] ref_i [WORDS];
    logic        ram_init = 1'b0;
    int          cyc = 0;

    // reference model state
    int  m_mode = M_IDLE, m_idx = 0, m_cnt = 0;
    bit  m_dpv = 0;

    bit          chk_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    int          beats = 0, last_at = 0, last_cnt = 0;
    int          rdy_mode = 0;
    int          dlog[$], ilog[$], dcyc[$], icyc[$];
    logic [31:0] drv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // synchronous-read RAMs on port 2
    always @(posedge CPU_CLK) begin
        cyc <= cyc + 1;
        if (!ram_init) begin
            for (int i = 0; i < WORDS; i++) begin
                dmem[i] <= ref_d[i];
                imem[i] <= ref_i[i];
            end
        end else begin
            if (dram_we2 == 4'hF) dmem[dram_a2[IW+1:2]] <= dram_wd2;
            if (iram_we2 == 4'hF) imem[iram_a2[IW+1:2]] <= iram_wd2;
        end
        dram_rd2 <= dmem[dram_a2[IW+1:2]];
        iram_rd2 <= imem[iram_a2[IW+1:2]];
    end

    // reference model: advanced on every clock edge from the bench's own inputs
    initial begin
        forever begin
            @(posedge CPU_CLK or negedge CPU_RST_N);
            if (!CPU_RST_N) begin
                m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_dpv = 0;
            end else begin
                case (m_mode)
                    M_IDLE, M_DONE: if (start) begin m_mode = M_LD_D; m_idx = 0; end
                    M_LD_D, M_LD_I: if (ld_valid) begin
                        if (m_mode == M_LD_D) ref_d[m_idx] = ld_data; else ref_i[m_idx] = ld_data;
                        if (ld_last || m_idx == WORDS - 1) begin
                            m_mode = m_mode + 1; m_idx = 0; m_cnt = 0;
                        end else m_idx++;
                    end
                    M_RST: begin
                        m_cnt++;
                        if (m_cnt == RSTC) begin m_mode = M_RUN; m_cnt = 0; end
                    end
                    M_RUN: begin
                        m_cnt++;
                        if (m_cnt == RUNC) begin m_mode = M_DP_D; m_idx = 0; m_dpv = 0; end
                    end
                    M_DP_D, M_DP_I: begin
                        if (!m_dpv) m_dpv = 1;
                        else if (dp_ready) begin
                            m_dpv = 0;
                            if (m_idx == WORDS - 1) begin m_mode = m_mode + 1; m_idx = 0; end
                            else m_idx++;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // per-cycle comparison against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge CPU_CLK);
            if (chk_en && CPU_RST_N) begin
                chk1("ld_ready", ld_ready, m_mode == M_LD_D || m_mode == M_LD_I);
                chk1("busy", busy, !(m_mode == M_IDLE || m_mode == M_DONE));
                chk1("done", done, m_mode == M_DONE);
                chk1("core_rst", core_rst, m_mode != M_RUN);
                chk1("dp_valid", dp_valid, m_dpv);
                chk1("dp_last", dp_last, m_dpv && m_mode == M_DP_I && m_idx == WORDS - 1);
                chk("dram_we2", 32'(dram_we2), (m_mode == M_LD_D && ld_valid) ? 32'hF : 32'h0);
                chk("iram_we2", 32'(iram_we2), (m_mode == M_LD_I && ld_valid) ? 32'hF : 32'h0);
                if (m_mode == M_LD_D && ld_valid) begin
                    chk("dram_a2_wr", dram_a2, m_idx * 4);
                    chk("dram_wd2", dram_wd2, ld_data);
                end
                if (m_mode == M_LD_I && ld_valid) begin
                    chk("iram_a2_wr", iram_a2, m_idx * 4);
                    chk("iram_wd2", iram_wd2, ld_data);
                end
                if (m_mode == M_DP_D && !m_dpv) chk("dram_a2_rd", dram_a2, m_idx * 4);
                if (m_mode == M_DP_I && !m_dpv) chk("iram_a2_rd", iram_a2, m_idx * 4);
                if (m_mode != M_LD_D && m_mode != M_DP_D) chk("dram_a2_idle", dram_a2, 0);
                if (m_mode != M_LD_I && m_mode != M_DP_I) chk("iram_a2_idle", iram_a2, 0);
                if (m_dpv) chk("dp_data", dp_data, (m_mode == M_DP_D) ? ref_d[m_idx] : ref_i[m_idx]);
                if (prev_stall) begin
                    chk1("stall_valid", dp_valid, 1'b1);
                    chk("stall_data", dp_data, prev_data);
                end
                prev_stall = dp_valid && !dp_ready;
                prev_data  = dp_data;
                if (dp_valid && dp_ready) begin
                    beats++;
                    if (dp_last) begin last_at = beats; last_cnt++; end
                end
                if (dram_we2 != 4'h0) begin dlog.push_back(dram_a2); dcyc.push_back(cyc); end
                if (iram_we2 != 4'h0) begin ilog.push_back(iram_a2); icyc.push_back(cyc); end
            end else begin
                prev_stall = 0;
            end
        end
    end

    // dump-side backpressure
    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int pi = 0;
        dp_ready = 1'b1;
        forever begin
            @(posedge CPU_CLK); #1;
            case (rdy_mode)
                0: dp_ready = 1'b1;
                1: begin dp_ready = pat[pi]; pi = (pi + 1) % 4; end
                default: dp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CPU_CLK); #1;
        start = 1'b0;
    endtask

    task automatic load_region(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    ld_valid = 1'b0; ld_last = 1'b0;
                    @(posedge CPU_CLK); #1;
                end
            end
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = with_last && (i == n - 1);
            drv.push_back(ld_data);
            @(posedge CPU_CLK); #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ld_ready"}, ld_ready, 1'b0);
        chk1({tag, "_dp_valid"}, dp_valid, 1'b0);
        chk1({tag, "_dp_last"}, dp_last, 1'b0);
        chk({tag, "_dp_data"}, dp_data, 0);
        chk1({tag, "_core_rst"}, core_rst, 1'b1);
        chk({tag, "_dram_a2"}, dram_a2, 0);
        chk({tag, "_iram_a2"}, iram_a2, 0);
        chk({tag, "_dram_wd2"}, dram_wd2, 0);
        chk({tag, "_iram_wd2"}, iram_wd2, 0);
        chk({tag, "_dram_we2"}, 32'(dram_we2), 0);
        chk({tag, "_iram_we2"}, 32'(iram_we2), 0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin @(negedge CPU_CLK); n++; end
        chk1(nm, done, 1'b1);
    endtask

    initial begin
        int hi, lo, dc, n;
        CPU_RST_N = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            ref_d[i] = $urandom;
            ref_i[i] = $urandom;
        end
        repeat (3) @(posedge CPU_CLK);
        #1;
        ram_init = 1'b1;
        chk_reset_vals("por");
        CPU_RST_N = 1'b1;
        chk_en = 1;

        // session 1: short regions, back-to-back beats, ready always high
        @(posedge CPU_CLK); #1;
        pulse_start();
        chk1("start_ld_ready", ld_ready, 1'b1);
        dlog.delete(); ilog.delete(); dcyc.delete(); icyc.delete(); drv.delete();
        load_region(3, 1, 0);
        load_region(2, 1, 0);
        chk("s1_dwrites", dlog.size(), 3);
        chk("s1_iwrites", ilog.size(), 2);
        if (dlog.size() == 3 && ilog.size() == 2) begin
            chk("s1_da0", dlog[0], 0); chk("s1_da1", dlog[1], 4); chk("s1_da2", dlog[2], 8);
            chk("s1_ia0", ilog[0], 0); chk("s1_ia1", ilog[1], 4);
            chk("s1_no_gap", icyc[1] - dcyc[0], 4);
            chk("s1_ref_d2", ref_d[2], drv[2]);
            chk("s1_ref_i1", ref_i[1], drv[4]);
        end
        hi = 0; n = 0;
        forever begin
            @(negedge CPU_CLK); n++;
            if (core_rst && n < 100) hi++; else break;
        end
        lo = 1; n = 0;
        forever begin
            @(negedge CPU_CLK); n++;
            if (lo == 10) start = 1'b1; else start = 1'b0;
            if (!core_rst && n < 100) lo++; else break;
        end
        start = 1'b0;
        chk("s1_rst_cycles", hi, RSTC);
        chk("s1_run_cycles", lo, RUNC);
        beats = 0; last_at = 0; last_cnt = 0;
        dc = 0;
        while (!done && dc < 200) begin dc++; @(negedge CPU_CLK); end
        chk("s1_dump_cycles", dc, 2 * 2 * WORDS);
        chk1("s1_done", done, 1'b1);
        chk("s1_beats", beats, 2 * WORDS);
        chk("s1_last_at", last_at, 2 * WORDS);
        chk("s1_last_cnt", last_cnt, 1);

        // session 2: restart from DONE, full data region without ld_last, stalled dump
        rdy_mode = 1;
        beats = 0; last_at = 0; last_cnt = 0;
        dlog.delete(); ilog.delete(); dcyc.delete(); icyc.delete();
        pulse_start();
        chk1("s2_restart_ld_ready", ld_ready, 1'b1);
        chk1("s2_restart_done", done, 1'b0);
        load_region(WORDS, 0, 1);
        load_region(3, 1, 1);
        chk("s2_dwrites", dlog.size(), WORDS);
        chk("s2_iwrites", ilog.size(), 3);
        if (dlog.size() == WORDS && ilog.size() > 0) begin
            chk("s2_dlast_addr", dlog[WORDS-1], (WORDS - 1) * 4);
            chk("s2_ifirst_addr", ilog[0], 0);
        end
        wait_done(600, "s2_done");
        chk("s2_beats", beats, 2 * WORDS);
        chk("s2_last_at", last_at, 2 * WORDS);

        // session 3: reset mid-load, then reset mid-dump
        rdy_mode = 2;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = $urandom;
            @(posedge CPU_CLK); #1;
        end
        #2;
        CPU_RST_N = 1'b0;
        #1;
        chk_reset_vals("midload");
        ld_valid = 1'b0;
        @(posedge CPU_CLK); #1;
        CPU_RST_N = 1'b1;
        pulse_start();
        load_region(2, 1, 0);
        load_region(2, 1, 0);
        beats = 0;
        n = 0;
        while (beats < 3 && n < 400) begin @(negedge CPU_CLK); n++; end
        chk1("s3_dump_reached", beats >= 3, 1'b1);
        #1;
        CPU_RST_N = 1'b0;
        #1;
        chk_reset_vals("middump");
        @(posedge CPU_CLK); #1;
        CPU_RST_N = 1'b1;

        // session 4: tiny reload, full dump shows partially loaded words intact
        beats = 0; last_at = 0;
        pulse_start();
        load_region(1, 1, 1);
        load_region(1, 1, 1);
        wait_done(800, "s4_done");
        chk("s4_beats", beats, 2 * WORDS);
        chk("s4_last_at", last_at, 2 * WORDS);

        @(negedge CPU_CLK);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
